// File: rtl/cnt_cmd_sequencer.sv
// Command front-end for the load/increment counter: turns LOAD/INC1/INCN commands
// into single-cycle ld/inc pulses while tracking a shadow of the counter value.
module cnt_cmd_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             ld,
  output logic             inc,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] shadow_cnt,
  output logic             busy,
  output logic             done,
  output logic             ovf_err,
  input  logic             err_clr
);

  typedef enum logic {IDLE, ISSUE} stateE;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC1 = 2'b10;
  localparam logic [1:0] OP_INCN = 2'b11;
  localparam logic [WIDTH-1:0] MAX = '1;

  stateE            state_q, state_d;
  logic             ld_q, ld_d;
  logic             inc_q, inc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             ovfPend_q, ovfPend_d;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] headroom;
  logic [WIDTH-1:0] kCnt;

  // Headroom fits in WIDTH bits because shadow never exceeds MAX.
  assign headroom  = MAX - shadow_q;
  assign kCnt      = (cmd_arg < headroom) ? cmd_arg : headroom;
  assign cmd_ready = rst && (state_q == IDLE);

  assign ld         = ld_q;
  assign inc        = inc_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign ovf_err    = ovf_q;
  assign data_out   = dataOut_q;
  assign shadow_cnt = shadow_q;

  always_comb begin
    state_d   = state_q;
    ld_d      = 1'b0;
    inc_d     = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ovfPend_d = ovfPend_q;
    remain_d  = remain_q;
    dataOut_d = dataOut_q;
    // Shadow follows the counter: it advances on the edge that consumes a pulse.
    shadow_d  = inc_q ? shadow_q + 1'b1 : shadow_q;
    ovf_d     = err_clr ? 1'b0 : ovf_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
          case (cmd_op)
            OP_LOAD: begin
              ld_d      = 1'b1;
              dataOut_d = cmd_arg;
              shadow_d  = cmd_arg;
            end
            OP_INC1: begin
              if (headroom != '0) inc_d = 1'b1;
              else                ovf_d = 1'b1;
            end
            OP_INCN: begin
              if (cmd_arg != '0) begin
                if (kCnt == '0) begin
                  ovf_d = 1'b1;
                end else begin
                  inc_d     = 1'b1;
                  remain_d  = kCnt - 1'b1;
                  ovfPend_d = (kCnt < cmd_arg);
                  done_d    = (kCnt == 1);
                  if ((kCnt == 1) && (kCnt < cmd_arg)) ovf_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          inc_d    = 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == 1) begin
            done_d = 1'b1;
            if (ovfPend_q) ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ld_q      <= 1'b0;
      inc_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovfPend_q <= 1'b0;
      remain_q  <= '0;
      dataOut_q <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      inc_q     <= inc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      ovfPend_q <= ovfPend_d;
      remain_q  <= remain_d;
      dataOut_q <= dataOut_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_cnt_cmd_sequencer.sv
// Bench for cnt_cmd_sequencer: a plan-based command model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cnt_cmd_sequencer;

  localparam int WIDTH = 3;
  localparam int MAXV  = 7;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC1 = 2'b10;
  localparam logic [1:0] OP_INCN = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_arg = '0;
  logic             ld, inc, busy, done, ovf_err;
  logic [WIDTH-1:0] data_out, shadow_cnt;
  logic             err_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  bit checkEn = 1'b0;

  cnt_cmd_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ld(ld), .inc(inc),
    .data_out(data_out), .shadow_cnt(shadow_cnt), .busy(busy), .done(done),
    .ovf_err(ovf_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  // One planned output cycle of a command, expanded from the command's rules.
  typedef struct {
    bit ld;
    bit inc;
    bit done;
    bit setOvf;
    bit doLoad;
    int arg;
  } stepT;

  stepT plan[$];
  stepT cur;
  bit   curActive = 1'b0;
  bit   modelAccepted = 1'b0;
  int   expShadow = 0;
  int   expData = 0;
  bit   expOvf = 1'b0;

  function automatic stepT mkStep(bit l, bit i, bit d, bit o, bit dl, int a);
    stepT s;
    s.ld = l; s.inc = i; s.done = d; s.setOvf = o; s.doLoad = dl; s.arg = a;
    return s;
  endfunction

  task automatic buildPlan(input logic [1:0] op, input int arg);
    int room;
    int k;
    room = MAXV - expShadow;
    case (op)
      OP_LOAD: plan.push_back(mkStep(1, 0, 1, 0, 1, arg));
      OP_INC1: plan.push_back(mkStep(0, room > 0, 1, room == 0, 0, 0));
      OP_INCN: begin
        k = (arg < room) ? arg : room;
        if (arg == 0)    plan.push_back(mkStep(0, 0, 1, 0, 0, 0));
        else if (k == 0) plan.push_back(mkStep(0, 0, 1, 1, 0, 0));
        else
          for (int j = 1; j <= k; j++)
            plan.push_back(mkStep(0, 1, j == k, (j == k) && (k < arg), 0, 0));
      end
      default: plan.push_back(mkStep(0, 0, 1, 0, 0, 0));
    endcase
  endtask

  // Model advances on the same edges as the design; reset wipes it immediately.
  always @(posedge clk or negedge rst) begin
    bit wasActive;
    if (!rst) begin
      plan.delete();
      curActive = 1'b0;
      cur = mkStep(0, 0, 0, 0, 0, 0);
      expShadow = 0;
      expData = 0;
      expOvf = 1'b0;
      modelAccepted = 1'b0;
    end else begin
      modelAccepted = 1'b0;
      wasActive = curActive;
      if (curActive && cur.inc) expShadow++;
      if (err_clr) expOvf = 1'b0;
      if (plan.size() > 0) begin
        cur = plan.pop_front();
        curActive = 1'b1;
      end else if (!wasActive && cmd_valid) begin
        buildPlan(cmd_op, int'(cmd_arg));
        cur = plan.pop_front();
        curActive = 1'b1;
        modelAccepted = 1'b1;
      end else begin
        curActive = 1'b0;
        cur = mkStep(0, 0, 0, 0, 0, 0);
      end
      if (curActive && cur.setOvf) expOvf = 1'b1;
      if (curActive && cur.doLoad) begin
        expShadow = cur.arg;
        expData = cur.arg;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at cycle %0d", name, actual, expected, cycleCnt);
    end
  endtask

  always @(negedge clk) begin
    if (rst && checkEn) begin
      checkOutput("cmp_ld", ld, curActive && cur.ld);
      checkOutput("cmp_inc", inc, curActive && cur.inc);
      checkOutput("cmp_done", done, curActive && cur.done);
      checkOutput("cmp_busy", busy, curActive);
      checkOutput("cmp_ready", cmd_ready, !curActive);
      checkOutput("cmp_ovf", ovf_err, expOvf);
      checkOutput("cmp_data", data_out, expData);
      checkOutput("cmp_shadow", shadow_cnt, expShadow);
      checkOutput("ld_inc_overlap", ld && inc, 0);
      checkOutput("inc_at_max", inc && (shadow_cnt == 3'(MAXV)), 0);
    end
  end

  // Presents a command and waits (bounded) for the model to accept it.
  task automatic applyStimulus(input logic [1:0] op, input int arg, input bit keepValid,
                               output int acceptCycle);
    bit got;
    got = 1'b0;
    cmd_op = op;
    cmd_arg = WIDTH'(arg);
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (modelAccepted) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual=no accept required=accept within 40 cycles");
    end
    acceptCycle = cycleCnt;
    if (!keepValid) cmd_valid = 1'b0;
  endtask

  task automatic loadWait(input int val);
    int t;
    applyStimulus(OP_LOAD, val, 0, t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int t1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ld", ld, 0);
    checkOutput("rst_inc", inc, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf_err, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_shadow", shadow_cnt, 0);
    checkOutput("rst_ready_low", cmd_ready, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    checkEn = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(OP_LOAD, 5, 0, t0);
    @(negedge clk);
    checkOutput("load_ld", ld, 1);
    checkOutput("load_data", data_out, 5);
    checkOutput("load_done", done, 1);
    checkOutput("load_shadow", shadow_cnt, 5);
    @(negedge clk);
    checkOutput("load_ready_t2", cmd_ready, 1);

    loadWait(2);
    applyStimulus(OP_INCN, 3, 0, t0);
    @(negedge clk);
    checkOutput("incn3_t1_inc", inc, 1);
    checkOutput("incn3_t1_done", done, 0);
    @(negedge clk);
    checkOutput("incn3_t2_inc", inc, 1);
    @(negedge clk);
    checkOutput("incn3_t3_inc", inc, 1);
    checkOutput("incn3_t3_done", done, 1);
    @(negedge clk);
    checkOutput("incn3_shadow", shadow_cnt, 5);
    checkOutput("incn3_ovf", ovf_err, 0);
    checkOutput("model_shadow_pin", expShadow, 5);

    loadWait(6);
    applyStimulus(OP_INCN, 3, 0, t0);
    @(negedge clk);
    checkOutput("sat_t1_inc", inc, 1);
    checkOutput("sat_t1_done", done, 1);
    checkOutput("sat_t1_ovf", ovf_err, 1);
    @(negedge clk);
    checkOutput("sat_inc_off", inc, 0);
    checkOutput("sat_shadow", shadow_cnt, 7);
    applyStimulus(OP_INC1, 0, 0, t0);
    @(negedge clk);
    checkOutput("inc1max_inc", inc, 0);
    checkOutput("inc1max_done", done, 1);
    checkOutput("inc1max_ovf", ovf_err, 1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    checkOutput("errclr_ovf", ovf_err, 0);
    checkOutput("model_ovf_pin", expOvf, 0);

    loadWait(0);
    applyStimulus(OP_INCN, 3, 1, t0);
    cmd_op = OP_LOAD;
    cmd_arg = 3'd1;
    applyStimulus(OP_LOAD, 1, 0, t1);
    checkOutput("held_load_gap", t1 - t0, 4);
    @(negedge clk);
    checkOutput("held_load_ld", ld, 1);
    checkOutput("held_load_shadow", shadow_cnt, 1);

    loadWait(0);
    applyStimulus(OP_INCN, 4, 0, t0);
    @(posedge clk);
    #2;
    checkOutput("midrst_pre_inc", inc, 1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_inc", inc, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_shadow", shadow_cnt, 0);
    checkOutput("midrst_ready", cmd_ready, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("postrst_ready", cmd_ready, 1);
    checkOutput("postrst_busy", busy, 0);

    loadWait(3);
    applyStimulus(OP_NOP, 5, 0, t0);
    @(negedge clk);
    checkOutput("nop_done", done, 1);
    checkOutput("nop_ld", ld, 0);
    checkOutput("nop_inc", inc, 0);
    checkOutput("nop_shadow", shadow_cnt, 3);
    applyStimulus(OP_INCN, 0, 0, t0);
    @(negedge clk);
    checkOutput("incn0_done", done, 1);
    checkOutput("incn0_inc", inc, 0);
    checkOutput("incn0_busy", busy, 1);
    applyStimulus(OP_INC1, 0, 0, t0);
    @(negedge clk);
    checkOutput("inc1_inc", inc, 1);
    @(negedge clk);
    checkOutput("inc1_shadow", shadow_cnt, 4);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_cmd_sequencer.md
Name: cnt_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the 3-bit load/increment counter.
- Accepts LOAD / INC / burst-INC commands over a valid/ready handshake and converts them into single-cycle ld and inc pulses plus load data for the counter.
- Keeps a shadow copy of the counter value and never issues an inc while the shadow is at its maximum value, so the counter's overflow check must never fire when this block drives it.

Parameters:
- WIDTH, 3, counter width in bits; also the width of cmd_arg, data_out and shadow_cnt.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_op  input  2  00 NOP, 01 LOAD, 10 INC1, 11 INCN
- cmd_arg  input  WIDTH  load value (LOAD) or increment count N (INCN); ignored otherwise
- ld  output  1  load strobe to counter
- inc  output  1  increment strobe to counter
- data_out  output  WIDTH  load data to counter data_in
- shadow_cnt  output  WIDTH  value the counter holds after all issued pulses
- busy  output  1  command in progress
- done  output  1  one-cycle pulse marking the final cycle of a command
- ovf_err  output  1  sticky flag: an increment was refused to prevent overflow
- err_clr  input  1  synchronous clear of ovf_err

Behaviour:
- MAX = 2^WIDTH-1. All outputs are registered except cmd_ready, which is defined as (state==IDLE) and is forced low while rst is low.
- Reset (rst=0, asynchronous, takes effect immediately, including mid-burst):
  - state goes to IDLE.
  - ld, inc, busy, done and ovf_err go to 0.
  - data_out and shadow_cnt go to 0, matching the counter's own reset value.
- FSM states: IDLE, ISSUE. The command is accepted on a cycle T where cmd_valid and cmd_ready are both high. The FSM moves to ISSUE and latches op, arg and remaining count.
- Timing for every op:
  - The first output cycle is T+1.
  - done is high in the last output cycle, and the FSM returns to IDLE on the next edge.
  - busy is high from T+1 through the done cycle.
  - The next command can be accepted the cycle after done.
- NOP: no ld/inc pulse; done at T+1.
- LOAD:
  - At T+1: ld=1, data_out=arg, done=1.
  - shadow_cnt=arg from T+1.
  - data_out holds the value until the next LOAD.
- INC1:
  - If shadow_cnt<MAX: inc=1 at T+1 and shadow_cnt increments.
  - Otherwise no inc pulse and ovf_err is set at T+1.
  - In both cases done at T+1.
- INCN with count N:
  - N=0: behaves as NOP.
  - Otherwise the block issues K = min(N, MAX-shadow_cnt) inc pulses on consecutive cycles T+1..T+K, and shadow_cnt increments with each pulse.
  - If K<N, ovf_err is set in the final cycle.
  - If K=0 (shadow already MAX), there is one cycle with no pulse, ovf_err is set, and done at T+1.
  - done coincides with the last pulse (or with the single idle cycle when K=0).
- ld and inc are never high in the same cycle. inc is never high while shadow_cnt==MAX.
- Width rule: shadow_cnt never wraps. Arithmetic for the headroom (MAX-shadow_cnt) is done in WIDTH bits, with no carry-out needed.
- err_clr:
  - Clears ovf_err on the next edge.
  - If err_clr and a new ovf_err set occur in the same cycle, the set wins.
  - err_clr does not affect the FSM.
- While busy, cmd_valid is ignored and cmd_ready stays low. Command inputs need not be held stable after the accept cycle.

Test Plan:
- Reset, then LOAD arg=5 accepted at T → ld=1 and data_out=5 at T+1, done at T+1, shadow_cnt=5, cmd_ready high again at T+2.
- From shadow 2, INCN N=3 → inc high at T+1..T+3, done at T+3, shadow_cnt=5, ovf_err=0.
- From shadow 6, INCN N=3 → exactly one inc at T+1, done at T+1, shadow_cnt=7, ovf_err=1; then INC1 → no inc, ovf_err stays 1; then err_clr → ovf_err=0.
- Hold cmd_valid high during an INCN burst with a LOAD on the inputs → LOAD is not accepted until the cycle after done; ld never overlaps inc.
- Assert rst low during the second pulse of an INCN N=4 from 0 → inc, busy, done and shadow_cnt drop to 0 immediately without a clock edge; after release, cmd_ready=1 and the state is IDLE.
- NOP and INCN N=0 → done at T+1, no ld or inc pulse, shadow_cnt unchanged.
